// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
//
// Coprocessor-0 register file. Receives the resolved exception from the
// MEM-stage exception unit. On an exception or ERET strobe it commits the
// architectural exception state: EPC, Cause.BD, Cause.ExcCode, Status.EXL
// and BadVAddr. It also runs the Count/Compare timer and samples the
// hardware interrupt lines. It serves MFC0 reads and gives the exception
// unit its live view of Status/Cause/EPC. On exception or ERET it redirects
// fetch in the same cycle.
//
// Ports
//   clk                  clock
//   rst                  asynchronous active-low reset
//   CP0RegWr_i           MTC0 write enable (WB stage)
//   CP0RegWrAddr_i[4:0]  MTC0 register number
//   CP0RegWrData_i[31:0] MTC0 write data
//   CP0RegRdAddr_i[4:0]  MFC0 register number
//   ExceptType_i[8:0]    one-hot-ish exception flags; lowest set bit wins
//   IsExceptionorEret_i  00 none, 01 exception, 10 eret, 11 none
//   IsDelaySlot_i        faulting instruction sits in a branch delay slot
//   CurrentPC_i[31:0]    PC of the faulting instruction
//   BadVAddr_i[31:0]     faulting address for address-error exceptions
//   HwInt_i[5:0]         hardware interrupt lines
//   CP0RegRdData_o       MFC0 read data (combinational)
//   CP0Status_o          Status register
//   CP0Cause_o           Cause register
//   CP0Epc_o             EPC register
//   Redirect_o           fetch redirect this cycle
//   RedirectPC_o         redirect target
//   TimerInt_o           Cause.TI
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CP0RegWr_i,
  input  logic [4:0]  CP0RegWrAddr_i,
  input  logic [31:0] CP0RegWrData_i,
  input  logic [4:0]  CP0RegRdAddr_i,
  input  logic [8:0]  ExceptType_i,
  input  logic [1:0]  IsExceptionorEret_i,
  input  logic        IsDelaySlot_i,
  input  logic [31:0] CurrentPC_i,
  input  logic [31:0] BadVAddr_i,
  input  logic [5:0]  HwInt_i,
  output logic [31:0] CP0RegRdData_o,
  output logic [31:0] CP0Status_o,
  output logic [31:0] CP0Cause_o,
  output logic [31:0] CP0Epc_o,
  output logic        Redirect_o,
  output logic [31:0] RedirectPC_o,
  output logic        TimerInt_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [1:0] EV_EXC  = 2'b01;
  localparam logic [1:0] EV_ERET = 2'b10;

  // Exception decode: {address_error, code_valid, exc_code[4:0]}.
  // The lowest set bit wins. The eret flag on its own carries no ExcCode,
  // so code_valid stays low and ExcCode holds.
  function automatic logic [6:0] exc_decode(input logic [8:0] t);
    logic [6:0] r;
    casez (t)
      9'b????????1: r = {1'b0, 1'b1, 5'h00};  // Interrupt
      9'b???????10: r = {1'b1, 1'b1, 5'h04};  // WrongAddressinIF
      9'b??????100: r = {1'b0, 1'b1, 5'h0A};  // ReservedInstruction
      9'b?????1000: r = {1'b0, 1'b1, 5'h08};  // Syscall
      9'b????10000: r = {1'b0, 1'b1, 5'h09};  // Break
      9'b???100000: r = {1'b0, 1'b1, 5'h0C};  // Overflow
      9'b??1000000: r = {1'b1, 1'b1, 5'h05};  // WrWrongAddressinMEM
      9'b?10000000: r = {1'b1, 1'b1, 5'h04};  // RdWrongAddressinMEM
      9'b100000000: r = {1'b0, 1'b0, 5'h00};  // Eret flag only
      default:      r = {1'b0, 1'b0, 5'h00};
    endcase
    return r;
  endfunction

  // Architectural state: only the implemented bit-fields are stored.
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        tick_q, tick_d;
  // Set once Compare has been written. This lets Compare==0 match after
  // software programs it, without a spurious match straight out of reset.
  logic        armed_q, armed_d;

  logic        wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s;
  logic        exc_s, eret_s;
  logic        exl_pre_s;
  logic [31:0] epc_mtc0_s;
  logic        timer_match_s;
  logic [6:0]  exc_info_s;
  logic [31:0] status_s, cause_s;
  logic [31:0] rd_data_s;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;

  assign wr_count_s   = CP0RegWr_i && (CP0RegWrAddr_i == REG_COUNT);
  assign wr_compare_s = CP0RegWr_i && (CP0RegWrAddr_i == REG_COMPARE);
  assign wr_status_s  = CP0RegWr_i && (CP0RegWrAddr_i == REG_STATUS);
  assign wr_cause_s   = CP0RegWr_i && (CP0RegWrAddr_i == REG_CAUSE);
  assign wr_epc_s     = CP0RegWr_i && (CP0RegWrAddr_i == REG_EPC);

  assign exc_s  = (IsExceptionorEret_i == EV_EXC);
  assign eret_s = (IsExceptionorEret_i == EV_ERET);

  // The MTC0 comes from the older WB instruction, so its effect is applied
  // before the exception logic looks at EXL or EPC.
  assign exl_pre_s  = wr_status_s ? CP0RegWrData_i[1] : exl_q;
  assign epc_mtc0_s = wr_epc_s ? CP0RegWrData_i : epc_q;

  assign timer_match_s = (count_q == compare_q) &&
                         ((compare_q != 32'd0) || armed_q);

  assign exc_info_s = exc_decode(ExceptType_i);

  assign status_s = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_s  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'd0};

  // Next state for the timer, the TI flag and the interrupt-pending bits.
  always_comb begin
    tick_d    = ~tick_q;
    armed_d   = armed_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count_s) begin
      count_d = CP0RegWrData_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    // A Compare write clears TI even when Count matches in the same cycle.
    if (wr_compare_s) begin
      compare_d = CP0RegWrData_i;
      armed_d   = 1'b1;
      ti_d      = 1'b0;
    end else if (timer_match_s) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end
    // IP7 carries the timer interrupt ORed with the top hardware line.
    ip_hw_d = {HwInt_i[5] | ti_q, HwInt_i[4:0]};
    if (wr_cause_s) begin
      ip_sw_d = CP0RegWrData_i[9:8];
    end else begin
      ip_sw_d = ip_sw_q;
    end
  end

  // Next state for Status, EPC, Cause.BD/ExcCode and BadVAddr.
  // MTC0 is applied first; an exception or ERET then overrides it.
  always_comb begin
    if (wr_status_s) begin
      im_d = CP0RegWrData_i[15:8];
      ie_d = CP0RegWrData_i[0];
    end else begin
      im_d = im_q;
      ie_d = ie_q;
    end
    exl_d      = exl_pre_s;
    epc_d      = epc_mtc0_s;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    badvaddr_d = badvaddr_q;
    if (exc_s) begin
      exl_d = 1'b1;
      if (exc_info_s[5]) begin
        exc_code_d = exc_info_s[4:0];
      end else begin
        exc_code_d = exc_code_q;
      end
      // A nested exception (EXL already set) keeps the original return
      // point and its delay-slot flag.
      if (!exl_pre_s) begin
        epc_d = IsDelaySlot_i ? (CurrentPC_i - 32'd4) : CurrentPC_i;
        bd_d  = IsDelaySlot_i;
      end else begin
        epc_d = epc_mtc0_s;
        bd_d  = bd_q;
      end
      if (exc_info_s[6]) begin
        badvaddr_d = BadVAddr_i;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (eret_s) begin
      exl_d = 1'b0;
    end else begin
      exl_d = exl_pre_s;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= STATUS_RESET[15:8];
      exl_q      <= STATUS_RESET[1];
      ie_q       <= STATUS_RESET[0];
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      badvaddr_q <= 32'd0;
      tick_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      tick_q     <= tick_d;
      armed_q    <= armed_d;
    end
  end

  // MFC0 read mux; unimplemented register numbers read as zero.
  always_comb begin
    case (CP0RegRdAddr_i)
      REG_BADVADDR: rd_data_s = badvaddr_q;
      REG_COUNT:    rd_data_s = count_q;
      REG_COMPARE:  rd_data_s = compare_q;
      REG_STATUS:   rd_data_s = status_s;
      REG_CAUSE:    rd_data_s = cause_s;
      REG_EPC:      rd_data_s = epc_q;
      default:      rd_data_s = 32'd0;
    endcase
  end

  // Same-cycle fetch redirect. ERET returns through EPC, forwarding a
  // same-cycle MTC0 to EPC.
  always_comb begin
    case (IsExceptionorEret_i)
      EV_EXC: begin
        redirect_s    = 1'b1;
        redirect_pc_s = EXC_VECTOR;
      end
      EV_ERET: begin
        redirect_s    = 1'b1;
        redirect_pc_s = epc_mtc0_s;
      end
      default: begin
        redirect_s    = 1'b0;
        redirect_pc_s = 32'd0;
      end
    endcase
  end

  assign CP0RegRdData_o = rd_data_s;
  assign CP0Status_o    = status_s;
  assign CP0Cause_o     = cause_s;
  assign CP0Epc_o       = epc_q;
  assign Redirect_o     = redirect_s;
  assign RedirectPC_o   = redirect_pc_s;
  assign TimerInt_o     = ti_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
//
// Self-checking bench for cp0_regfile. A behavioural model holds each CP0
// register as a plain 32-bit word and updates it once per clock from the
// architectural rules. Inputs are driven 1 time unit after the rising edge.
// Outputs are compared 2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        CP0RegWr_i;
  logic [4:0]  CP0RegWrAddr_i;
  logic [31:0] CP0RegWrData_i;
  logic [4:0]  CP0RegRdAddr_i;
  logic [8:0]  ExceptType_i;
  logic [1:0]  IsExceptionorEret_i;
  logic        IsDelaySlot_i;
  logic [31:0] CurrentPC_i;
  logic [31:0] BadVAddr_i;
  logic [5:0]  HwInt_i;
  logic [31:0] CP0RegRdData_o;
  logic [31:0] CP0Status_o;
  logic [31:0] CP0Cause_o;
  logic [31:0] CP0Epc_o;
  logic        Redirect_o;
  logic [31:0] RedirectPC_o;
  logic        TimerInt_o;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk                 (clk),
    .rst                 (rst),
    .CP0RegWr_i          (CP0RegWr_i),
    .CP0RegWrAddr_i      (CP0RegWrAddr_i),
    .CP0RegWrData_i      (CP0RegWrData_i),
    .CP0RegRdAddr_i      (CP0RegRdAddr_i),
    .ExceptType_i        (ExceptType_i),
    .IsExceptionorEret_i (IsExceptionorEret_i),
    .IsDelaySlot_i       (IsDelaySlot_i),
    .CurrentPC_i         (CurrentPC_i),
    .BadVAddr_i          (BadVAddr_i),
    .HwInt_i             (HwInt_i),
    .CP0RegRdData_o      (CP0RegRdData_o),
    .CP0Status_o         (CP0Status_o),
    .CP0Cause_o          (CP0Cause_o),
    .CP0Epc_o            (CP0Epc_o),
    .Redirect_o          (Redirect_o),
    .RedirectPC_o        (RedirectPC_o),
    .TimerInt_o          (TimerInt_o)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Model state: whole-register images.
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_badv;
  logic        m_tick, m_armed;
  logic [4:0]  code_tab [8] = '{5'h00, 5'h04, 5'h0A, 5'h08, 5'h09, 5'h0C, 5'h05, 5'h04};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status  = 32'h0040_0000;
    m_cause   = 32'd0;
    m_epc     = 32'd0;
    m_count   = 32'd0;
    m_compare = 32'd0;
    m_badv    = 32'd0;
    m_tick    = 1'b0;
    m_armed   = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of architectural behaviour given the current inputs.
  task automatic model_step();
    logic [31:0] ns, nc, ne, ncnt, ncmp, nb;
    logic        nti, narm, exl_before;
    logic [5:0]  hw;
    int          low;
    ns = m_status; nc = m_cause; ne = m_epc; ncmp = m_compare; nb = m_badv;
    narm = m_armed;
    nti  = m_cause[30];
    hw   = {HwInt_i[5] | m_cause[30], HwInt_i[4:0]};
    if ((m_count == m_compare) && ((m_compare != 32'd0) || m_armed)) nti = 1'b1;
    ncnt = m_tick ? (m_count + 32'd1) : m_count;
    if (CP0RegWr_i) begin
      if (CP0RegWrAddr_i == 5'd9)  ncnt = CP0RegWrData_i;
      if (CP0RegWrAddr_i == 5'd11) begin ncmp = CP0RegWrData_i; narm = 1'b1; nti = 1'b0; end
      if (CP0RegWrAddr_i == 5'd12) ns = (CP0RegWrData_i & 32'h0000_FF03) | 32'h0040_0000;
      if (CP0RegWrAddr_i == 5'd13) nc[9:8] = CP0RegWrData_i[9:8];
      if (CP0RegWrAddr_i == 5'd14) ne = CP0RegWrData_i;
    end
    if (IsExceptionorEret_i == 2'b01) begin
      exl_before = ns[1];
      ns[1] = 1'b1;
      low = -1;
      for (int i = 7; i >= 0; i--) if (ExceptType_i[i]) low = i;
      if (low >= 0) begin
        nc[6:2] = code_tab[low];
        if (low == 1 || low == 6 || low == 7) nb = BadVAddr_i;
      end
      if (!exl_before) begin
        ne = IsDelaySlot_i ? (CurrentPC_i - 32'd4) : CurrentPC_i;
        nc[31] = IsDelaySlot_i;
      end
    end else if (IsExceptionorEret_i == 2'b10) begin
      ns[1] = 1'b0;
    end
    nc[15:10] = hw;
    nc[30]    = nti;
    m_status = ns; m_cause = nc; m_epc = ne; m_count = ncnt; m_compare = ncmp;
    m_badv = nb; m_armed = narm; m_tick = ~m_tick;
  endtask

  task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [8:0] et, input logic [1:0] ev,
                       input logic dly, input logic [31:0] pc, input logic [31:0] bva,
                       input logic [5:0] hw);
    CP0RegWr_i = wr; CP0RegWrAddr_i = wa; CP0RegWrData_i = wd; CP0RegRdAddr_i = ra;
    ExceptType_i = et; IsExceptionorEret_i = ev; IsDelaySlot_i = dly;
    CurrentPC_i = pc; BadVAddr_i = bva; HwInt_i = hw;
  endtask

  task automatic idle(input logic [4:0] ra);
    drive(1'b0, 5'd0, 32'd0, ra, 9'd0, 2'b00, 1'b0, 32'd0, 32'd0, 6'd0);
  endtask

  // Compare every output against the model for the current cycle.
  task automatic settle_check();
    #2;
    chk("status", CP0Status_o, m_status);
    chk("cause", CP0Cause_o, m_cause);
    chk("epc", CP0Epc_o, m_epc);
    chk("timer_int", 32'(TimerInt_o), 32'(m_cause[30]));
    chk("mfc0", CP0RegRdData_o, model_read(CP0RegRdAddr_i));
    if (IsExceptionorEret_i != 2'b11)
      chk("redirect", 32'(Redirect_o), 32'(IsExceptionorEret_i != 2'b00));
    if (IsExceptionorEret_i == 2'b01)
      chk("rpc_exc", RedirectPC_o, EXC_VEC);
    else if (IsExceptionorEret_i == 2'b10)
      chk("rpc_eret", RedirectPC_o,
          (CP0RegWr_i && CP0RegWrAddr_i == 5'd14) ? CP0RegWrData_i : m_epc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle_check();
    tick();
  endtask

  task automatic run_random(input int n);
    logic [8:0]  et;
    logic [1:0]  ev;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          r;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0: wa = 5'd9;
        1: wa = 5'd11;
        2: wa = 5'd12;
        3: wa = 5'd13;
        4: wa = 5'd14;
        5: wa = 5'd0;
        6: wa = 5'd15;
        default: wa = 5'd31;
      endcase
      wd = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 12));
      r  = $urandom_range(0, 15);
      ev = (r < 10) ? 2'b00 : (r < 13) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      et = 9'($urandom);
      if (et[7:0] == 8'd0) et[$urandom_range(0, 7)] = 1'b1;
      drive($urandom_range(0, 3) == 0, wa, wd, 5'($urandom_range(0, 31)), et, ev,
            1'($urandom), $urandom, $urandom, 6'($urandom));
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0;
    idle(5'd15);
    model_reset();
    #12;
    // Reset state while still held in reset.
    chk("rst_status", CP0Status_o, 32'h0040_0000);
    chk("rst_cause", CP0Cause_o, 32'd0);
    chk("rst_epc", CP0Epc_o, 32'd0);
    chk("rst_mfc0_15", CP0RegRdData_o, 32'd0);
    chk("rst_redirect", 32'(Redirect_o), 32'd0);
    rst = 1'b1;
    cyc();

    // Syscall, not in a delay slot, EXL=0.
    drive(1'b0, 5'd0, 32'd0, 5'd13, 9'h008, 2'b01, 1'b0, 32'h8000_1000, 32'd0, 6'd0);
    settle_check();
    chk("sys_redirect", 32'(Redirect_o), 32'd1);
    chk("sys_rpc", RedirectPC_o, 32'hBFC0_0380);
    tick();
    idle(5'd14);
    chk("sys_epc", CP0Epc_o, 32'h8000_1000);
    chk("sys_code", 32'(CP0Cause_o[6:2]), 32'h08);
    chk("sys_exl", 32'(CP0Status_o[1]), 32'd1);
    chk("sys_bd", 32'(CP0Cause_o[31]), 32'd0);
    cyc();

    // Plain ERET back to EPC, clearing EXL.
    drive(1'b0, 5'd0, 32'd0, 5'd12, 9'h100, 2'b10, 1'b0, 32'd0, 32'd0, 6'd0);
    settle_check();
    chk("eret_rpc", RedirectPC_o, 32'h8000_1000);
    tick();
    chk("eret_exl", 32'(CP0Status_o[1]), 32'd0);

    // Overflow in a delay slot, then a nested Break with EXL=1.
    drive(1'b0, 5'd0, 32'd0, 5'd13, 9'h020, 2'b01, 1'b1, 32'h8000_2004, 32'd0, 6'd0);
    cyc();
    chk("ov_epc", CP0Epc_o, 32'h8000_2000);
    chk("ov_bd", 32'(CP0Cause_o[31]), 32'd1);
    chk("ov_code", 32'(CP0Cause_o[6:2]), 32'h0C);
    drive(1'b0, 5'd0, 32'd0, 5'd13, 9'h010, 2'b01, 1'b0, 32'h8000_5550, 32'd0, 6'd0);
    cyc();
    chk("nest_epc", CP0Epc_o, 32'h8000_2000);
    chk("nest_bd", 32'(CP0Cause_o[31]), 32'd1);
    chk("nest_code", 32'(CP0Cause_o[6:2]), 32'h09);

    // Address errors: read then write.
    drive(1'b0, 5'd0, 32'd0, 5'd8, 9'h080, 2'b01, 1'b0, 32'h8000_0040, 32'h0000_0003, 6'd0);
    cyc();
    idle(5'd8);
    chk("rdadr_code", 32'(CP0Cause_o[6:2]), 32'h04);
    chk("rdadr_badv", CP0RegRdData_o, 32'h0000_0003);
    drive(1'b0, 5'd0, 32'd0, 5'd8, 9'h040, 2'b01, 1'b0, 32'h8000_0044, 32'h1234_5678, 6'd0);
    cyc();
    chk("wradr_code", 32'(CP0Cause_o[6:2]), 32'h05);

    // MTC0 EPC forwarded into a same-cycle ERET.
    drive(1'b1, 5'd14, 32'h8000_3000, 5'd14, 9'h100, 2'b10, 1'b0, 32'd0, 32'd0, 6'd0);
    settle_check();
    chk("fwd_rpc", RedirectPC_o, 32'h8000_3000);
    tick();
    chk("fwd_exl", 32'(CP0Status_o[1]), 32'd0);
    chk("fwd_epc", CP0Epc_o, 32'h8000_3000);

    // Timer: Compare=5, Count=0, wait (bounded) for TI.
    drive(1'b1, 5'd11, 32'd5, 5'd9, 9'd0, 2'b00, 1'b0, 32'd0, 32'd0, 6'd0);
    cyc();
    drive(1'b1, 5'd9, 32'd0, 5'd9, 9'd0, 2'b00, 1'b0, 32'd0, 32'd0, 6'd0);
    cyc();
    idle(5'd9);
    for (int i = 0; i < 40 && !TimerInt_o; i++) cyc();
    chk("ti_set", 32'(TimerInt_o), 32'd1);
    chk("ti_cause30", 32'(CP0Cause_o[30]), 32'd1);
    cyc();
    chk("ti_ip7", 32'(CP0Cause_o[15]), 32'd1);
    drive(1'b1, 5'd11, 32'd1000, 5'd13, 9'd0, 2'b00, 1'b0, 32'd0, 32'd0, 6'd0);
    cyc();
    chk("ti_clear", 32'(TimerInt_o), 32'd0);

    // Random traffic, with an asynchronous reset in the middle.
    run_random(300);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_status", CP0Status_o, 32'h0040_0000);
    chk("mid_rst_cause", CP0Cause_o, 32'd0);
    chk("mid_rst_epc", CP0Epc_o, 32'd0);
    chk("mid_rst_ti", 32'(TimerInt_o), 32'd0);
    rst = 1'b1;
    run_random(300);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
